// File: rtl/cpu_init_sequencer_pkg.sv
// Shared definitions for the CPU init sequencer: state encoding, default
// parameter values and the phase-counter width helper.
`default_nettype none

package cpu_init_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4
  } state_t;

  localparam int         DEF_SW_WIDTH      = 8;
  localparam logic [7:0] DEF_INIT_SWITCHES = 8'h80;
  localparam int         DEF_RESET_CYCLES  = 1;
  localparam int         DEF_HOLD_CYCLES   = 2;

  // The counter must be able to hold the larger of the two phase lengths.
  function automatic int phase_width(input int reset_cycles, input int hold_cycles);
    int longest;
    longest = (reset_cycles > hold_cycles) ? reset_cycles : hold_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_init_sequencer_edge_detect.sv
// Rising-edge detector with a registered history bit; the pulse is valid in
// the same cycle the input is first seen high.
`default_nettype none

module edge_detect (
  input  logic clock,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

`default_nettype wire

// File: rtl/cpu_init_sequencer.sv
// Drives a CPU's reset/stop buttons and switch bus through a power-on init
// sequence, then free-run or single-step operation with a step counter.
`default_nettype none

module cpu_init_sequencer
  import cpu_init_sequencer_pkg::*;
#(
  parameter int                  SW_WIDTH      = DEF_SW_WIDTH,
  parameter logic [SW_WIDTH-1:0] INIT_SWITCHES = SW_WIDTH'(DEF_INIT_SWITCHES),
  parameter int                  RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int                  HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                clock,
  input  logic                resetButton,
  input  logic                reinit_req,
  input  logic                step_mode,
  input  logic                step_req,
  input  logic [SW_WIDTH-1:0] switches_in,
  output logic                cpu_reset_n,
  output logic                cpu_stop_n,
  output logic [SW_WIDTH-1:0] switches_out,
  output logic                done_init,
  output logic [15:0]         step_count
);

  localparam int            PW         = phase_width(RESET_CYCLES, HOLD_CYCLES);
  localparam logic [PW-1:0] RESET_LAST = PW'(RESET_CYCLES);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);

  state_t              state, state_nx;
  logic [PW-1:0]       phase, phase_nx;
  logic                step_rise;
  logic                reset_n_nx, stop_n_nx, done_nx;
  logic [SW_WIDTH-1:0] switches_nx;
  logic [15:0]         count_nx;
  logic                cur_active, nx_active;

  edge_detect u_step_edge (
    .clock (clock),
    .rst_n (resetButton),
    .din   (step_req),
    .rise  (step_rise)
  );

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    if (reinit_req) begin
      state_nx = S_RESET;
      phase_nx = '0;
    end else begin
      unique case (state)
        // RESET counts one extra edge so cpu_reset_n rises RESET_CYCLES
        // edges after the first edge sampled out of reset.
        S_RESET: begin
          if (phase == RESET_LAST) begin
            state_nx = S_HOLD;
            phase_nx = '0;
          end else begin
            phase_nx = phase + PW'(1);
          end
        end
        S_HOLD: begin
          if (phase == HOLD_LAST) begin
            state_nx = S_RUN;
            phase_nx = '0;
          end else begin
            phase_nx = phase + PW'(1);
          end
        end
        S_RUN: begin
          if (step_mode) state_nx = S_PAUSE;
        end
        S_PAUSE: begin
          if (!step_mode)     state_nx = S_RUN;
          else if (step_rise) state_nx = S_STEP;
        end
        S_STEP: begin
          state_nx = S_PAUSE;
        end
        default: begin
          state_nx = S_RESET;
          phase_nx = '0;
        end
      endcase
    end

    cur_active  = (state == S_RUN) || (state == S_PAUSE) || (state == S_STEP);
    nx_active   = (state_nx == S_RUN) || (state_nx == S_PAUSE) || (state_nx == S_STEP);
    reset_n_nx  = (state_nx != S_RESET);
    stop_n_nx   = (state_nx == S_RUN) || (state_nx == S_STEP);
    done_nx     = nx_active;
    // User switches pass through only once the CPU was already running.
    switches_nx = (cur_active && nx_active) ? switches_in : INIT_SWITCHES;
    count_nx    = (state == S_STEP) ? step_count + 16'd1 : step_count;
  end

  always_ff @(posedge clock) begin
    if (!resetButton) begin
      state        <= S_RESET;
      phase        <= '0;
      cpu_reset_n  <= 1'b0;
      cpu_stop_n   <= 1'b0;
      switches_out <= INIT_SWITCHES;
      done_init    <= 1'b0;
      step_count   <= 16'd0;
    end else begin
      state        <= state_nx;
      phase        <= phase_nx;
      cpu_reset_n  <= reset_n_nx;
      cpu_stop_n   <= stop_n_nx;
      switches_out <= switches_nx;
      done_init    <= done_nx;
      step_count   <= count_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_init_sequencer.sv
// Bench for cpu_init_sequencer: default and (5,7) instances driven in lockstep
// and compared every cycle against a timing-based behavioural model.
`default_nettype none

module tb_cpu_init_sequencer;

  logic        clock = 1'b0;
  logic        resetButton, reinit_req, step_mode, step_req;
  logic [7:0]  switches_in;
  logic        rn_a, sn_a, done_a, rn_b, sn_b, done_b;
  logic [7:0]  sw_a, sw_b;
  logic [15:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;
  int edge_no;
  int stop_highs;

  always #5 clock = ~clock;

  cpu_init_sequencer dut_a (
    .clock(clock), .resetButton(resetButton), .reinit_req(reinit_req),
    .step_mode(step_mode), .step_req(step_req), .switches_in(switches_in),
    .cpu_reset_n(rn_a), .cpu_stop_n(sn_a), .switches_out(sw_a),
    .done_init(done_a), .step_count(cnt_a)
  );

  cpu_init_sequencer #(.RESET_CYCLES(5), .HOLD_CYCLES(7)) dut_b (
    .clock(clock), .resetButton(resetButton), .reinit_req(reinit_req),
    .step_mode(step_mode), .step_req(step_req), .switches_in(switches_in),
    .cpu_reset_n(rn_b), .cpu_stop_n(sn_b), .switches_out(sw_b),
    .done_init(done_b), .step_count(cnt_b)
  );

  // since: edges counted from the first edge out of reset/reinit (-1 = held).
  typedef struct {
    int          since;
    bit          paused;
    bit          stepping;
    bit          prev;
    logic [15:0] cnt;
    logic [7:0]  sw;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_step(input mdl_t m, input int r, input int h,
                                    input logic rb, input logic ri, input logic sm,
                                    input logic sr, input logic [7:0] si);
    bit rise;
    rise = sr && !m.prev;
    if (!rb) begin
      m.since = -1; m.paused = 0; m.stepping = 0; m.prev = 0; m.cnt = 16'd0;
    end else begin
      m.prev = sr;
      if (m.stepping) m.cnt = m.cnt + 16'd1;
      if (ri) begin
        m.since = -1; m.paused = 0; m.stepping = 0;
      end else begin
        if (m.since <= r + h) m.since = m.since + 1;
        if (m.since > r + h) begin
          if (m.stepping)    m.stepping = 0;
          else if (m.paused) begin
            if (!sm)       m.paused = 0;
            else if (rise) m.stepping = 1;
          end else if (sm) m.paused = 1;
        end
      end
    end
    m.sw = (m.since > r + h) ? si : 8'h80;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic check_model(input string id, input mdl_t m, input int r, input int h,
                             input logic rn, input logic sn, input logic [7:0] sw,
                             input logic dn, input logic [15:0] cn);
    logic done_e;
    done_e = (m.since >= r + h);
    chk({id, ".cpu_reset_n"}, 16'(rn), 16'(m.since >= r));
    chk({id, ".cpu_stop_n"},  16'(sn), 16'(done_e && (!m.paused || m.stepping)));
    chk({id, ".done_init"},   16'(dn), 16'(done_e));
    chk({id, ".switches_out"}, 16'(sw), 16'(m.sw));
    chk({id, ".step_count"},  cn, m.cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    ma = mdl_step(ma, 1, 2, resetButton, reinit_req, step_mode, step_req, switches_in);
    mb = mdl_step(mb, 5, 7, resetButton, reinit_req, step_mode, step_req, switches_in);
    @(negedge clock);
    check_model("a", ma, 1, 2, rn_a, sn_a, sw_a, done_a, cnt_a);
    check_model("b", mb, 5, 7, rn_b, sn_b, sw_b, done_b, cnt_b);
  endtask

  // Literal release timeline from the first edge sampled out of reset.
  task automatic release_timeline();
    for (int e = 0; e <= 12; e++) begin
      edge_no = e;
      tick();
      chk("rel_a.cpu_reset_n", 16'(rn_a), 16'(e >= 1));
      if (e <= 3) begin
        chk("rel_a.cpu_stop_n", 16'(sn_a), 16'(e >= 3));
        chk("rel_a.done_init", 16'(done_a), 16'(e >= 3));
        chk("rel_a.switches_out", 16'(sw_a), 16'h0080);
      end
      chk("rel_b.cpu_reset_n", 16'(rn_b), 16'(e >= 5));
      chk("rel_b.cpu_stop_n", 16'(sn_b), 16'(e >= 12));
      chk("rel_b.switches_out", 16'(sw_b), 16'h0080);
    end
  endtask

  task automatic step_pulse(input int high_cycles);
    step_req = 1'b1;
    repeat (high_cycles) begin
      tick();
      if (sn_a) stop_highs++;
    end
    step_req = 1'b0;
    tick();
    if (sn_a) stop_highs++;
  endtask

  initial begin
    ma = '{since: -1, paused: 0, stepping: 0, prev: 0, cnt: 16'd0, sw: 8'h80};
    mb = ma;
    edge_no = -1;
    resetButton = 1'b0; reinit_req = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    switches_in = 8'h00;
    @(negedge clock);

    // Reset values.
    tick(); tick();
    chk("rst.cpu_reset_n", 16'(rn_a), 16'd0);
    chk("rst.switches_out", 16'(sw_a), 16'h0080);
    chk("rst.step_count", cnt_a, 16'd0);

    // Release and init timing for both parameter sets.
    resetButton = 1'b1;
    release_timeline();

    // Switch pass-through with one cycle latency.
    switches_in = 8'h3C;
    tick();
    chk("run.switches_out", 16'(sw_a), 16'h003C);

    // Single-step: three short pulses and one held pulse -> four steps.
    step_mode = 1'b1;
    tick();
    chk("pause.cpu_stop_n", 16'(sn_a), 16'd0);
    stop_highs = 0;
    step_pulse(1); step_pulse(1); step_pulse(1); step_pulse(10);
    chk("step.stop_highs", 16'(stop_highs), 16'd4);
    chk("step.count_a", cnt_a, 16'd4);
    chk("step.count_b", cnt_b, 16'd4);

    // Reinit from pause keeps step_count and replays the sequence.
    reinit_req = 1'b1;
    tick();
    chk("reinit.done_init", 16'(done_a), 16'd0);
    reinit_req = 1'b0;
    repeat (15) tick();
    chk("reinit.count_a", cnt_a, 16'd4);
    chk("reinit.done_init_b", 16'(done_b), 16'd1);

    // Reset during hold aborts; restart timing matches power-on.
    step_mode = 1'b0;
    reinit_req = 1'b1; tick(); reinit_req = 1'b0;
    tick(); tick();
    resetButton = 1'b0;
    tick();
    chk("hold_rst.cpu_reset_n", 16'(rn_a), 16'd0);
    chk("hold_rst.step_count", cnt_a, 16'd0);
    resetButton = 1'b1;
    release_timeline();

    // Randomised operation.
    edge_no = 1000;
    for (int i = 0; i < 2500; i++) begin
      resetButton = ($urandom_range(199) != 0);
      reinit_req  = ($urandom_range(99) == 0);
      if ($urandom_range(39) == 0) step_mode = ~step_mode;
      step_req    = ($urandom_range(2) == 0);
      switches_in = 8'($urandom);
      tick();
      edge_no++;
    end

    // Step counter wrap on the (5,7) instance.
    resetButton = 1'b1; reinit_req = 1'b0; step_req = 1'b0; step_mode = 1'b1;
    repeat (20) tick();
    force dut_b.step_count = 16'hFFFE;
    #1;
    release dut_b.step_count;
    mb.cnt = 16'hFFFE;
    stop_highs = 0;
    step_pulse(1);
    chk("wrap.count_ffff", cnt_b, 16'hFFFF);
    step_pulse(1);
    chk("wrap.count_zero", cnt_b, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_init_sequencer.md
CPU_INIT_SEQUENCER -- requirements
Module: cpu_init_sequencer

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 8: width of the switch bus presented to the CPU.
REQ-002 SHALL have parameter INIT_SWITCHES, default 8'h80: switch value driven during initialisation.
REQ-003 SHALL have parameter RESET_CYCLES, default 1, legal range >= 1: cycles the CPU reset is held low.
REQ-004 SHALL have parameter HOLD_CYCLES, default 2, legal range >= 1: cycles the CPU stop is held low after reset release.
REQ-005 SHALL have port clock  input  1  system clock; one clock only, all logic on its rising edge.
REQ-006 SHALL have port resetButton  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port reinit_req  input  1  level request to restart the init sequence.
REQ-008 SHALL have port step_mode  input  1  1 = single-step operation after init.
REQ-009 SHALL have port step_req  input  1  step request; rising edge counts.
REQ-010 SHALL have port switches_in  input  SW_WIDTH  user switch value.
REQ-011 SHALL have port cpu_reset_n  output  1  drives the CPU reset button, active-low.
REQ-012 SHALL have port cpu_stop_n  output  1  drives the CPU stop button, active-low.
REQ-013 SHALL have port switches_out  output  SW_WIDTH  switch value presented to the CPU.
REQ-014 SHALL have port done_init  output  1  high once the init sequence completes.
REQ-015 SHALL have port step_count  output  16  number of completed single steps.

Function
REQ-016 SHALL implement FSM states S_RESET, S_HOLD, S_RUN, S_PAUSE, S_STEP; all outputs registered.
REQ-017 S_RESET SHALL drive cpu_reset_n=0, cpu_stop_n=0, switches_out=INIT_SWITCHES, done_init=0, and move to S_HOLD after RESET_CYCLES cycles.
REQ-018 S_HOLD SHALL drive cpu_reset_n=1, cpu_stop_n=0, switches_out=INIT_SWITCHES, and move to S_RUN after HOLD_CYCLES cycles.
REQ-019 S_RUN SHALL drive cpu_reset_n=1, cpu_stop_n=1, done_init=1, and switches_out = switches_in registered, with 1-cycle latency.
REQ-020 If resetButton is deasserted at edge k, cpu_reset_n SHALL rise at edge k+RESET_CYCLES, and cpu_stop_n and done_init SHALL rise at edge k+RESET_CYCLES+HOLD_CYCLES.
REQ-021 In S_RUN with step_mode=1, the FSM SHALL go to S_PAUSE, with cpu_stop_n=0 on the next cycle.
REQ-022 In S_PAUSE, a step_req rising edge (0 in previous cycle, 1 now) SHALL go to S_STEP, with cpu_stop_n=1 for exactly one cycle, then return to S_PAUSE.
REQ-023 step_count SHALL increment by 1 on each exit from S_STEP and wrap from 16'hFFFF to 0.
REQ-024 step_req held high SHALL produce one step only, and step_req edges outside S_PAUSE SHALL be ignored.
REQ-025 In S_PAUSE with step_mode=0, the FSM SHALL return to S_RUN.
REQ-026 A step_mode drop during S_STEP SHALL take effect after that step completes.
REQ-027 reinit_req=1 in any state SHALL force S_RESET next cycle: phase counter cleared, done_init=0, step_count preserved.
REQ-028 reinit_req SHALL have priority over step_req and step_mode.
REQ-029 reinit_req held high SHALL keep the FSM in S_RESET, with the count restarting on each cycle until it is released.
REQ-030 The phase counter width SHALL be $clog2(max(RESET_CYCLES,HOLD_CYCLES)+1), with no overflow for legal parameters.

Reset
REQ-031 With resetButton=0 at a rising edge, outputs SHALL be: state S_RESET, phase counter 0, cpu_reset_n=0, cpu_stop_n=0, switches_out=INIT_SWITCHES, done_init=0, step_count=0, step_req history=0.
REQ-032 Reset asserted mid-sequence or mid-step SHALL abort it immediately; no pending step is carried across reset.

Structure
REQ-033 A shared package SHALL hold the state encoding enum (3 bits) and the default parameter constants.
REQ-034 One sub-module, edge_detect (registered rising-edge detector), SHALL be used for step_req; everything else stays in one module.

Verification
REQ-035 Defaults, release resetButton at edge 0 -> cpu_reset_n=1 from edge 1; cpu_stop_n=1, done_init=1 from edge 3; switches_out=8'h80 throughout edges 0-3.
REQ-036 In S_RUN, switches_in=8'h3C -> switches_out=8'h3C one cycle later.
REQ-037 step_mode=1, then three step_req pulses plus one held 10 cycles -> four 1-cycle cpu_stop_n highs, step_count=4.
REQ-038 reinit_req pulsed during S_PAUSE with step_count=4 -> done_init=0 next cycle, full sequence replays, step_count stays 4.
REQ-039 resetButton=0 during S_HOLD -> all outputs at reset values next edge; restart timing identical to REQ-035.
REQ-040 RESET_CYCLES=5, HOLD_CYCLES=7, step_count preloaded by 65535 steps, one more step -> edges 5/12 for release, step_count wraps to 0.
